// File: rtl/battle_machine_gen2.sv
// Turn-based battle controller: menu, timed dodge phase, action choice and attack resolution.
// Emits registered movement/damage instructions for the player sprite and tracks monster damage.
module battle_machine_gen2 #(
  parameter int unsigned HPW         = 8,
  parameter int unsigned MON_HP_MAX  = 100,
  parameter int unsigned HEAL_AMT    = 10,
  parameter int unsigned DODGE_TICKS = 300
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [3:0]     keyboard,
  input  logic           tick,
  input  logic           is_death,
  input  logic           atk_pass,
  input  logic           is_dmg_complete,
  input  logic           heal,
  input  logic [HPW-1:0] dmg_mon,
  input  logic [7:0]     damage,
  output logic [7:0]     state,
  output logic [15:0]    player_instr,
  output logic           is_move,
  output logic           start_dmg,
  output logic [HPW-1:0] mon_hp,
  output logic [7:0]     turn_cnt
);

  localparam int unsigned TW = 16;

  typedef enum logic [3:0] {
    PG_MENU   = 4'h1,
    PG_DODGE  = 4'h9,
    PG_ATTACK = 4'hA,
    PG_ACTION = 4'hB,
    PG_WIN    = 4'hC,
    PG_LOSE   = 4'hD
  } page_e;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_HPY = 4'h1;
  localparam logic [3:0] OP_DPY = 4'h2;
  localparam logic [3:0] OP_MOV = 4'h5;

  localparam logic [3:0] KEY_W     = 4'd1;
  localparam logic [3:0] KEY_D     = 4'd2;
  localparam logic [3:0] KEY_S     = 4'd3;
  localparam logic [3:0] KEY_A     = 4'd4;
  localparam logic [3:0] KEY_J     = 4'd5;
  localparam logic [3:0] KEY_K     = 4'd6;
  localparam logic [3:0] KEY_L     = 4'd7;
  localparam logic [3:0] KEY_SPACE = 4'd8;

  localparam logic [15:0] INSTR_HEAL = {OP_HPY, 8'(HEAL_AMT), 4'b0};

  page_e           page, page_nxt;
  logic [3:0]      key_q;
  logic [TW-1:0]   timer, timer_nxt;
  logic [HPW-1:0]  mon_hp_nxt, hp_sat;
  logic [HPW:0]    hp_sum;
  logic [7:0]      turn_nxt, turn_inc;
  logic [15:0]     instr_nxt;
  logic            move_nxt, start_nxt, press;

  assign state = {page, 4'b0};

  // State and registered outputs; key_q tracks keyboard even in reset so a held key is not a press.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      page         <= PG_MENU;
      key_q        <= keyboard;
      timer        <= TW'(DODGE_TICKS);
      mon_hp       <= '0;
      turn_cnt     <= 8'd0;
      player_instr <= 16'd0;
      is_move      <= 1'b0;
      start_dmg    <= 1'b0;
    end else begin
      page         <= page_nxt;
      key_q        <= keyboard;
      timer        <= timer_nxt;
      mon_hp       <= mon_hp_nxt;
      turn_cnt     <= turn_nxt;
      player_instr <= instr_nxt;
      is_move      <= move_nxt;
      start_dmg    <= start_nxt;
    end
  end

  // Next-state, next-output and saturating arithmetic.
  always_comb begin
    page_nxt   = page;
    timer_nxt  = timer;
    mon_hp_nxt = mon_hp;
    turn_nxt   = turn_cnt;
    instr_nxt  = {OP_NOP, 12'd0};
    move_nxt   = 1'b0;
    start_nxt  = 1'b0;

    press    = (keyboard != 4'd0) && (keyboard != key_q);
    hp_sum   = {1'b0, mon_hp} + {1'b0, dmg_mon};
    hp_sat   = hp_sum[HPW] ? {HPW{1'b1}} : hp_sum[HPW-1:0];
    turn_inc = (turn_cnt == 8'hFF) ? turn_cnt : turn_cnt + 8'd1;

    case (page)
      PG_MENU: begin
        if (press && keyboard == KEY_SPACE) begin
          page_nxt   = PG_DODGE;
          mon_hp_nxt = '0;
          turn_nxt   = 8'd0;
          timer_nxt  = TW'(DODGE_TICKS);
        end
      end
      PG_DODGE: begin
        if (is_death) begin
          page_nxt = PG_LOSE;
        end else if (tick && timer == TW'(1)) begin
          page_nxt = PG_ACTION;
        end else begin
          // Timer floors at 1; only the tick that finds it at 1 ends the phase.
          if (tick && timer > TW'(1)) timer_nxt = timer - TW'(1);
          if (is_dmg_complete) begin
            instr_nxt = heal ? INSTR_HEAL : {OP_DPY, damage, 4'b0};
          end else begin
            case (keyboard)
              KEY_W:   begin instr_nxt = {OP_MOV, 8'd0, 4'b0}; move_nxt = 1'b1; end
              KEY_D:   begin instr_nxt = {OP_MOV, 8'd1, 4'b0}; move_nxt = 1'b1; end
              KEY_S:   begin instr_nxt = {OP_MOV, 8'd2, 4'b0}; move_nxt = 1'b1; end
              KEY_A:   begin instr_nxt = {OP_MOV, 8'd3, 4'b0}; move_nxt = 1'b1; end
              default: ;
            endcase
          end
        end
      end
      PG_ACTION: begin
        if (press && keyboard == KEY_J) begin
          page_nxt  = PG_ATTACK;
          start_nxt = 1'b1;
        end else if (press && (keyboard == KEY_K || keyboard == KEY_L)) begin
          page_nxt  = PG_DODGE;
          turn_nxt  = turn_inc;
          timer_nxt = TW'(DODGE_TICKS);
          if (keyboard == KEY_K) instr_nxt = INSTR_HEAL;
        end
      end
      PG_ATTACK: begin
        if (atk_pass) begin
          mon_hp_nxt = hp_sat;
          if (hp_sat >= HPW'(MON_HP_MAX)) begin
            page_nxt = PG_WIN;
          end else begin
            page_nxt  = PG_DODGE;
            turn_nxt  = turn_inc;
            timer_nxt = TW'(DODGE_TICKS);
          end
        end
      end
      PG_WIN, PG_LOSE: begin
        if (press && keyboard == KEY_SPACE) page_nxt = PG_MENU;
      end
      default: page_nxt = PG_MENU;
    endcase
  end

endmodule

// File: tb/tb_battle_machine_gen2.sv
// Scoreboard bench for battle_machine_gen2: expected outputs queued per driven cycle, compared after the edge.
module tb_battle_machine_gen2;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] keyboard;
  logic       tick, is_death, atk_pass, is_dmg_complete, heal;
  logic [7:0] dmg_mon, damage;

  logic [7:0]  state_a, state_b, mon_hp_a, mon_hp_b, turn_a, turn_b;
  logic [15:0] instr_a, instr_b;
  logic        move_a, move_b, sdmg_a, sdmg_b;

  typedef struct packed {
    logic        sel;
    logic [7:0]  st;
    logic [15:0] ins;
    logic        mv;
    logic        sd;
    logic [7:0]  mon;
    logic [7:0]  trn;
  } exp_t;

  exp_t  sb_q[$];
  logic  cur_sel = 1'b0;
  string phase = "init";
  int    n_checks = 0;
  int    n_pass   = 0;

  always #5 clk = ~clk;

  battle_machine_gen2 #(.HPW(8), .MON_HP_MAX(100), .HEAL_AMT(10), .DODGE_TICKS(3)) u_dut_a (
    .clk(clk), .rst_n(rst_n), .keyboard(keyboard), .tick(tick), .is_death(is_death),
    .atk_pass(atk_pass), .is_dmg_complete(is_dmg_complete), .heal(heal),
    .dmg_mon(dmg_mon), .damage(damage), .state(state_a), .player_instr(instr_a),
    .is_move(move_a), .start_dmg(sdmg_a), .mon_hp(mon_hp_a), .turn_cnt(turn_a)
  );

  battle_machine_gen2 #(.HPW(8), .MON_HP_MAX(255), .HEAL_AMT(10), .DODGE_TICKS(3)) u_dut_b (
    .clk(clk), .rst_n(rst_n), .keyboard(keyboard), .tick(tick), .is_death(is_death),
    .atk_pass(atk_pass), .is_dmg_complete(is_dmg_complete), .heal(heal),
    .dmg_mon(dmg_mon), .damage(damage), .state(state_b), .player_instr(instr_b),
    .is_move(move_b), .start_dmg(sdmg_b), .mon_hp(mon_hp_b), .turn_cnt(turn_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s.%s got=%0h exp=%0h", phase, tag, got, exp);
  endtask

  // Queue the expected post-edge outputs, clock once, then retire the entry.
  task automatic step(input logic [7:0] st, input logic [15:0] ins, input logic mv,
                      input logic sd, input logic [7:0] mon, input logic [7:0] trn);
    exp_t e;
    sb_q.push_back('{sel: cur_sel, st: st, ins: ins, mv: mv, sd: sd, mon: mon, trn: trn});
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("state",     e.sel ? state_b  : state_a,  e.st);
    check("instr",     e.sel ? instr_b  : instr_a,  e.ins);
    check("is_move",   e.sel ? move_b   : move_a,   e.mv);
    check("start_dmg", e.sel ? sdmg_b   : sdmg_a,   e.sd);
    check("mon_hp",    e.sel ? mon_hp_b : mon_hp_a, e.mon);
    check("turn_cnt",  e.sel ? turn_b   : turn_a,   e.trn);
  endtask

  task automatic idle_inputs();
    keyboard = 4'd0; tick = 1'b0; is_death = 1'b0; atk_pass = 1'b0;
    is_dmg_complete = 1'b0; heal = 1'b0; dmg_mon = 8'd0; damage = 8'd0;
  endtask

  // Three ticks with no keys: two stay in DODGE, third moves to ACTION.
  task automatic run_out_dodge(input logic [7:0] mon, input logic [7:0] trn);
    keyboard = 4'd0; tick = 1'b1;
    step(8'h90, 16'h0000, 1'b0, 1'b0, mon, trn);
    step(8'h90, 16'h0000, 1'b0, 1'b0, mon, trn);
    step(8'hB0, 16'h0000, 1'b0, 1'b0, mon, trn);
    tick = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_inputs();
    rst_n = 1'b0;

    phase = "reset";
    keyboard = 4'd8;
    step(8'h10, 16'h0000, 1'b0, 1'b0, 8'd0, 8'd0);
    step(8'h10, 16'h0000, 1'b0, 1'b0, 8'd0, 8'd0);
    rst_n = 1'b1;
    phase = "held_space";
    step(8'h10, 16'h0000, 1'b0, 1'b0, 8'd0, 8'd0);
    keyboard = 4'd0;
    step(8'h10, 16'h0000, 1'b0, 1'b0, 8'd0, 8'd0);

    phase = "menu_space";
    keyboard = 4'd8;
    step(8'h90, 16'h0000, 1'b0, 1'b0, 8'd0, 8'd0);
    for (int i = 0; i < 9; i++) step(8'h90, 16'h0000, 1'b0, 1'b0, 8'd0, 8'd0);

    phase = "dodge_timer";
    keyboard = 4'd1;
    step(8'h90, 16'h5000, 1'b1, 1'b0, 8'd0, 8'd0);
    tick = 1'b1;
    step(8'h90, 16'h5000, 1'b1, 1'b0, 8'd0, 8'd0);
    tick = 1'b0;
    step(8'h90, 16'h5000, 1'b1, 1'b0, 8'd0, 8'd0);
    tick = 1'b1;
    step(8'h90, 16'h5000, 1'b1, 1'b0, 8'd0, 8'd0);
    step(8'hB0, 16'h0000, 1'b0, 1'b0, 8'd0, 8'd0);
    tick = 1'b0;

    phase = "action_l";
    step(8'hB0, 16'h0000, 1'b0, 1'b0, 8'd0, 8'd0);
    keyboard = 4'd7;
    step(8'h90, 16'h0000, 1'b0, 1'b0, 8'd0, 8'd1);

    phase = "dodge_dmg";
    keyboard = 4'd2; is_dmg_complete = 1'b1; damage = 8'h14;
    step(8'h90, 16'h2140, 1'b0, 1'b0, 8'd0, 8'd1);
    heal = 1'b1;
    step(8'h90, 16'h10A0, 1'b0, 1'b0, 8'd0, 8'd1);
    heal = 1'b0; is_dmg_complete = 1'b0;
    phase = "dodge_move";
    step(8'h90, 16'h5010, 1'b1, 1'b0, 8'd0, 8'd1);
    keyboard = 4'd3;
    step(8'h90, 16'h5020, 1'b1, 1'b0, 8'd0, 8'd1);
    keyboard = 4'd4;
    step(8'h90, 16'h5030, 1'b1, 1'b0, 8'd0, 8'd1);
    keyboard = 4'd5;
    step(8'h90, 16'h0000, 1'b0, 1'b0, 8'd0, 8'd1);
    run_out_dodge(8'd0, 8'd1);

    phase = "action_k";
    keyboard = 4'd6;
    step(8'h90, 16'h10A0, 1'b0, 1'b0, 8'd0, 8'd2);
    keyboard = 4'd0;
    step(8'h90, 16'h0000, 1'b0, 1'b0, 8'd0, 8'd2);
    run_out_dodge(8'd0, 8'd2);

    phase = "attack_miss";
    keyboard = 4'd5;
    step(8'hA0, 16'h0000, 1'b0, 1'b1, 8'd0, 8'd2);
    keyboard = 4'd0;
    step(8'hA0, 16'h0000, 1'b0, 1'b0, 8'd0, 8'd2);
    atk_pass = 1'b1; dmg_mon = 8'd95;
    step(8'h90, 16'h0000, 1'b0, 1'b0, 8'd95, 8'd3);
    atk_pass = 1'b0;
    run_out_dodge(8'd95, 8'd3);

    phase = "attack_win";
    keyboard = 4'd5;
    step(8'hA0, 16'h0000, 1'b0, 1'b1, 8'd95, 8'd3);
    keyboard = 4'd0; atk_pass = 1'b1; dmg_mon = 8'd10;
    step(8'hC0, 16'h0000, 1'b0, 1'b0, 8'd105, 8'd3);
    atk_pass = 1'b0;
    step(8'hC0, 16'h0000, 1'b0, 1'b0, 8'd105, 8'd3);
    keyboard = 4'd8;
    step(8'h10, 16'h0000, 1'b0, 1'b0, 8'd105, 8'd3);
    keyboard = 4'd0;
    step(8'h10, 16'h0000, 1'b0, 1'b0, 8'd105, 8'd3);
    keyboard = 4'd8;
    step(8'h90, 16'h0000, 1'b0, 1'b0, 8'd0, 8'd0);

    phase = "death";
    keyboard = 4'd2; is_dmg_complete = 1'b1; damage = 8'h14; is_death = 1'b1;
    step(8'hD0, 16'h0000, 1'b0, 1'b0, 8'd0, 8'd0);
    idle_inputs();
    step(8'hD0, 16'h0000, 1'b0, 1'b0, 8'd0, 8'd0);

    phase = "reset_mid_attack";
    keyboard = 4'd8;
    step(8'h10, 16'h0000, 1'b0, 1'b0, 8'd0, 8'd0);
    keyboard = 4'd0;
    step(8'h10, 16'h0000, 1'b0, 1'b0, 8'd0, 8'd0);
    keyboard = 4'd8;
    step(8'h90, 16'h0000, 1'b0, 1'b0, 8'd0, 8'd0);
    run_out_dodge(8'd0, 8'd0);
    keyboard = 4'd5;
    step(8'hA0, 16'h0000, 1'b0, 1'b1, 8'd0, 8'd0);
    keyboard = 4'd0; atk_pass = 1'b1; dmg_mon = 8'd10; rst_n = 1'b0;
    step(8'h10, 16'h0000, 1'b0, 1'b0, 8'd0, 8'd0);
    idle_inputs();
    rst_n = 1'b1;

    phase = "saturate";
    cur_sel = 1'b1;
    step(8'h10, 16'h0000, 1'b0, 1'b0, 8'd0, 8'd0);
    keyboard = 4'd8;
    step(8'h90, 16'h0000, 1'b0, 1'b0, 8'd0, 8'd0);
    run_out_dodge(8'd0, 8'd0);
    keyboard = 4'd5;
    step(8'hA0, 16'h0000, 1'b0, 1'b1, 8'd0, 8'd0);
    keyboard = 4'd0; atk_pass = 1'b1; dmg_mon = 8'd250;
    step(8'h90, 16'h0000, 1'b0, 1'b0, 8'd250, 8'd1);
    atk_pass = 1'b0;
    run_out_dodge(8'd250, 8'd1);
    keyboard = 4'd5;
    step(8'hA0, 16'h0000, 1'b0, 1'b1, 8'd250, 8'd1);
    keyboard = 4'd0; atk_pass = 1'b1; dmg_mon = 8'd20;
    step(8'hC0, 16'h0000, 1'b0, 1'b0, 8'd255, 8'd1);
    idle_inputs();

    phase = "end";
    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
